ni_inject_arbiter: RTL and testbench
====================================

Name: ni_inject_arbiter

Overview:
- Shares the single NoC injection port of one tile (flit_out, flit_out_wr, credit_in) among N local requesters, e.g. the CPU NI DMA, a debug streamer and a trace unit.
- Grants round-robin at packet granularity and locks the grant from header flit to tail flit.
- Tracks downstream credits per VC and never issues a flit without a credit.
- Sits between the requesters and the router local port, in the same clock domain as the NoC.

Parameters:
- N, 3: number of requesters (2..8).
- V, 2: virtual channels per port.
- B, 4: buffer depth per VC, i.e. the initial credit count.
- Fpay, 32: payload width.
- Fw, 2+V+Fpay: flit width. Layout: bit Fw-1 is header, bit Fw-2 is tail, bits [Fw-3:Fpay] are the one-hot VC field, bits [Fpay-1:0] are payload.

Ports:
- clk  in  1  NoC clock.
- reset  in  1  asynchronous, active-high reset.
- req_flit  in  N*Fw  flit from requester i at bits [(i+1)*Fw-1 : i*Fw].
- req_valid  in  N  requester i presents a flit.
- req_ready  out  N  flit of requester i is accepted this cycle.
- flit_out  out  Fw  registered flit to the router.
- flit_out_wr  out  1  flit_out is valid this cycle.
- credit_in  in  V  one credit returned per asserted bit.
- busy  out  1  a packet grant is held.
- credit_err  out  1  sticky flag: a credit was returned to an already-full counter.

Behaviour:
- Reset (asynchronous) values:
  - outputs: flit_out=0, flit_out_wr=0, req_ready=0, busy=0, credit_err=0;
  - FSM in IDLE, round-robin pointer at 0;
  - every credit counter at B. Counter width is clog2(B+1).
- FSM states:
  - IDLE: candidates are requesters with req_valid=1 and header bit=1. The winner is the first candidate at or after rr_ptr, modulo N. In the same cycle: latch the winner index as gnt and the VC field as lvc, set busy=1, go to LOCK. No flit is accepted in the IDLE cycle. Requesters asserting valid without a header are never granted in IDLE.
  - LOCK: req_ready[gnt] = req_valid[gnt] && credit[lvc]!=0. All other req_ready bits are 0.
- On an accept:
  - flit_out <= req_flit[gnt] with the VC field overwritten by lvc;
  - flit_out_wr <= 1 in the next cycle, giving exactly 1 cycle of latency;
  - credit[lvc] is decremented.
- Tail accept (tail=1): rr_ptr <= gnt+1 mod N, busy <= 0, next state IDLE. A single-flit packet (header=1 and tail=1) takes IDLE->LOCK->IDLE. Back-to-back packets cost one bubble cycle, in IDLE.
- Header flit accepted while in LOCK after the first flit: forwarded unchanged as data. The protocol is the requester's responsibility.
- Credits:
  - Per VC, in each cycle: next = cur - sent + credit_in[v].
  - Simultaneous send and return on the same VC leaves the count unchanged.
  - A return while the count is at B holds the count at B and sets credit_err, which stays set until reset.
  - A send is impossible at 0 because ready is gated.
- Credit stall: while credit[lvc]=0 the grant is held and req_ready stays 0. Flits wait at the requester; nothing is dropped.
- req_valid deasserted mid-packet: the grant is held indefinitely. There is no timeout.
- flit_out_wr is a 1-cycle pulse per accepted flit. flit_out holds its last value when flit_out_wr=0.
- Reset asserted mid-packet: the packet is abandoned, credits return to B, and the router is reset with the same signal.
- lvc is not one-hot (zero or multi-hot): treat the VC as the lowest set bit. With zero set bits, use VC 0.

Decomposition:
- Shared noc_pkg holds:
  - the flit field offsets (HDR_BIT, TAIL_BIT, VC_LSB);
  - a clog2 function;
  - a credit-width constant function.
- One natural sub-module is ni_credit_counter, one instance per VC: inputs dec, inc; outputs count, nonzero, overflow.
- The round-robin select stays inline.

Test Plan:
- Single requester 0 sends a 3-flit packet on VC0 (H, B, T), no credit return -> flit_out_wr pulses on 3 consecutive cycles starting 2 cycles after req_valid; credit[0] goes 4->1; busy drops after the tail.
- Requesters 0, 1 and 2 each hold a 2-flit packet, all valid in the same cycle, rr_ptr=0 -> output packet order is 0, 1, 2, with a 1-cycle bubble between packets and no interleaving of flits.
- Requester 1 sends a 6-flit packet on VC1 with B=4 and no credits returned -> 4 flits out, then req_ready[1]=0 stall. Pulse credit_in=2'b10 twice -> remaining 2 flits out, 1 cycle after each pulse.
- Send on VC0 and return credit_in[0] in the same cycle, repeated for 10 cycles -> credit[0] stays at 3 after the initial drop; no stall; credit_err=0.
- Return credit_in=2'b01 while the count is at 4 -> count stays 4; credit_err=1 and stays 1 until reset.
- Assert reset asynchronously mid-packet, between clock edges -> flit_out_wr=0, req_ready=0 and busy=0 immediately; after release credits are 4/4 and a new packet from requester 2 is granted first from rr_ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared NoC helpers for the tile injection path.
//   - flit field offsets: header bit, tail bit and VC field LSB. The flit is
//     {hdr, tail, vc[V-1:0], payload[Fpay-1:0]}, so the offsets depend on the
//     flit width or the payload width.
//   - clog2(): ceiling log2, usable in constant expressions.
//   - credit_width(): width of a counter that must hold 0..depth.
// -----------------------------------------------------------------------------
package noc_pkg;

    // The header flag is the flit MSB.
    function automatic int hdr_bit(input int fw);
        return fw - 1;
    endfunction

    // The tail flag sits just below the header flag.
    function automatic int tail_bit(input int fw);
        return fw - 2;
    endfunction

    // The one-hot VC field starts right above the payload.
    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    // The counter holds 0..depth inclusive, and it is never narrower than 1 bit.
    function automatic int credit_width(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// -----------------------------------------------------------------------------
// ni_credit_counter
//   Downstream credit tracker for one virtual channel. The counter starts full
//   at B, drops on each flit sent, and rises on each credit returned. When a
//   send and a return happen in the same cycle, the count does not change.
//   A return that reaches a full counter is dropped. It is flagged on overflow
//   for that cycle only, and the parent keeps the sticky copy.
//
// Ports
//   clk       in   NoC clock
//   reset     in   asynchronous active-high reset (count returns to B)
//   dec       in   a flit was sent on this VC this cycle
//   inc       in   a credit was returned for this VC this cycle
//   nonzero   out  at least one credit is available
//   overflow  out  a return was dropped because the counter was full (1 cycle)
// -----------------------------------------------------------------------------
module ni_credit_counter
    import noc_pkg::*;
#(
    parameter int B  = 4,
    parameter int CW = credit_width(B)
)
(
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic nonzero,
    output logic overflow
);

    localparam logic [CW-1:0] FULL = CW'(B);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (dec && !inc) begin
            // The parent gates sends with nonzero, so this never underflows.
            count_d = count_q - ONE;
        end else if (inc && !dec) begin
            if (count_q == FULL) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign nonzero = (count_q != '0);

endmodule

// File: rtl/ni_inject_arbiter.sv
// -----------------------------------------------------------------------------
// ni_inject_arbiter
//   This block shares the single NoC injection port of a tile among N local
//   requesters.
//   - Arbitration is round-robin and happens per packet. A header flit wins
//     the grant in IDLE. The grant is then held in LOCK until the tail flit is
//     accepted.
//   - A flit is accepted only when the locked VC holds a downstream credit.
//   - Accepted flits are registered onto flit_out, with one cycle of latency.
//     The flit's VC field is replaced by the VC latched from the header.
//
// Ports
//   clk          in   NoC clock
//   reset        in   asynchronous active-high reset
//   req_flit     in   N*Fw   flit of requester i at [(i+1)*Fw-1 : i*Fw]
//   req_valid    in   N      requester i presents a flit
//   req_ready    out  N      flit of requester i is accepted this cycle
//   flit_out     out  Fw     registered flit to the router local port
//   flit_out_wr  out  1      flit_out is valid this cycle (1-cycle pulse)
//   credit_in    in   V      one credit returned per asserted bit
//   busy         out  1      a packet grant is held
//   credit_err   out  1      sticky: a credit was returned to a full counter
// -----------------------------------------------------------------------------
module ni_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N    = 3,
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    parameter int Fw   = 2 + V + Fpay
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [N*Fw-1:0] req_flit,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic            credit_err
);

    localparam int PW   = (clog2(N) < 1) ? 1 : clog2(N);
    localparam int CW   = credit_width(B);
    localparam int HDR  = hdr_bit(Fw);
    localparam int TAIL = tail_bit(Fw);
    localparam int VCL  = vc_lsb(Fpay);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]    state_q,       state_d;
    logic [PW-1:0] rr_ptr_q,      rr_ptr_d;
    logic [PW-1:0] gnt_q,         gnt_d;
    logic [V-1:0]  lvc_q,         lvc_d;        // always one-hot once granted
    logic          busy_q,        busy_d;
    logic [Fw-1:0] flit_out_q,    flit_out_d;
    logic          flit_out_wr_q, flit_out_wr_d;
    logic          credit_err_q,  credit_err_d;

    logic [Fw-1:0] flit_arr [N];
    logic [N-1:0]  cand;
    logic [V-1:0]  credit_nz;
    logic [V-1:0]  credit_dec;
    logic [V-1:0]  credit_ovf;

    // Unpack the requester flits. Only a valid flit that carries a header
    // can start a packet.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign flit_arr[gi] = req_flit[gi*Fw +: Fw];
            assign cand[gi]     = req_valid[gi] & req_flit[gi*Fw + HDR];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < V; gi++) begin : g_vc
            ni_credit_counter #(
                .B  (B),
                .CW (CW)
            ) u_credit (
                .clk      (clk),
                .reset    (reset),
                .dec      (credit_dec[gi]),
                .inc      (credit_in[gi]),
                .nonzero  (credit_nz[gi]),
                .overflow (credit_ovf[gi])
            );
        end
    endgenerate

    // Round-robin pick: the first candidate at or after rr_ptr, wrapping mod N.
    logic          win_found;
    logic [PW-1:0] win_idx;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (32'(rr_ptr_q) + 32'(k)) % 32'(N);
            if (!win_found && cand[idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PW-1:0];
            end
        end
    end

    // Reduce the header's VC field to one hot bit: keep the lowest set bit,
    // and use VC 0 when the field is empty.
    logic [V-1:0] win_vc_raw;
    logic [V-1:0] win_vc_low;
    logic [V-1:0] win_vc_onehot;

    assign win_vc_raw    = flit_arr[win_idx][VCL +: V];
    assign win_vc_low    = win_vc_raw & (~win_vc_raw + V'(1));
    assign win_vc_onehot = (win_vc_raw == '0) ? V'(1) : win_vc_low;

    logic [Fw-1:0] cur_flit;
    logic          accept;
    logic [PW-1:0] gnt_next;

    assign cur_flit = flit_arr[gnt_q];
    assign accept   = (state_q == ST_LOCK) && req_valid[gnt_q] && ((credit_nz & lvc_q) != '0);
    assign gnt_next = (gnt_q == PW'(N - 1)) ? '0 : gnt_q + PW'(1);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        lvc_d         = lvc_q;
        busy_d        = busy_q;
        flit_out_d    = flit_out_q;
        flit_out_wr_d = 1'b0;
        credit_dec    = '0;
        credit_err_d  = credit_err_q | (credit_ovf != '0);

        case (state_q)
            ST_IDLE: begin
                // The grant cycle itself accepts nothing. This is the one
                // bubble between packets.
                if (win_found) begin
                    gnt_d   = win_idx;
                    lvc_d   = win_vc_onehot;
                    busy_d  = 1'b1;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    flit_out_d             = cur_flit;
                    flit_out_d[VCL +: V]   = lvc_q;
                    flit_out_wr_d          = 1'b1;
                    credit_dec             = lvc_q;
                    // A header seen after the first flit is passed through as
                    // data. Only the tail flag ends the grant.
                    if (cur_flit[TAIL]) begin
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = gnt_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            lvc_q         <= '0;
            busy_q        <= 1'b0;
            flit_out_q    <= '0;
            flit_out_wr_q <= 1'b0;
            credit_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            lvc_q         <= lvc_d;
            busy_q        <= busy_d;
            flit_out_q    <= flit_out_d;
            flit_out_wr_q <= flit_out_wr_d;
            credit_err_q  <= credit_err_d;
        end
    end

    assign flit_out    = flit_out_q;
    assign flit_out_wr = flit_out_wr_q;
    assign busy        = busy_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ni_inject_arbiter
//   The driver pushes packets into per-requester queues and presents flits to
//   the DUT. A packet-level reference model runs on the falling edge. It decides
//   grants from the round-robin rule and tracks credits with plain integers.
//   It pushes each expected flit onto a scoreboard queue. A monitor runs just
//   after the rising edge, pops that queue whenever the DUT writes a flit, and
//   compares the flit. It also checks busy and credit_err against the model.
// -----------------------------------------------------------------------------
module tb_ni_inject_arbiter;

    localparam int N    = 3;
    localparam int V    = 2;
    localparam int B    = 4;
    localparam int FPAY = 32;
    localparam int FW   = 2 + V + FPAY;

    typedef logic [FW-1:0] flit_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*FW-1:0] req_flit;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [FW-1:0]   flit_out;
    logic            flit_out_wr;
    logic [V-1:0]    credit_in;
    logic            busy;
    logic            credit_err;

    always #5 clk = ~clk;

    ni_inject_arbiter #(.N(N), .V(V), .B(B), .Fpay(FPAY), .Fw(FW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_flit    (req_flit),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .flit_out    (flit_out),
        .flit_out_wr (flit_out_wr),
        .credit_in   (credit_in),
        .busy        (busy),
        .credit_err  (credit_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state (written only by the initial block) -----
    flit_t src_q [N][$];

    // ---------------- reference model state (written only by the model) -----
    bit           m_locked = 1'b0;
    int           m_gnt    = 0;
    int           m_vc     = 0;
    int           m_ptr    = 0;
    int           m_cred [V];
    bit           m_err    = 1'b0;
    bit [N-1:0]   m_acc    = '0;
    flit_t        exp_q [$];

    initial begin
        for (int v = 0; v < V; v++) m_cred[v] = B;
    end

    // Reference model. Each falling edge, it looks at the stable inputs and
    // decides what the next rising edge must do.
    always @(negedge clk) begin
        bit [N-1:0] rdy;
        int         sent [V];
        flit_t      f;
        bit         found;
        int         r;
        rdy = '0;
        for (int v = 0; v < V; v++) sent[v] = 0;
        if (reset) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_err    = 1'b0;
            m_acc    = '0;
            for (int v = 0; v < V; v++) m_cred[v] = B;
            exp_q.delete();
        end else begin
            if (!m_locked) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    r = (m_ptr + k) % N;
                    if (!found && req_valid[r] && req_flit[r*FW + FW - 1]) begin
                        found = 1'b1;
                        m_gnt = r;
                    end
                end
                if (found) begin
                    m_locked = 1'b1;
                    f = req_flit[m_gnt*FW +: FW];
                    m_vc = 0;
                    for (int v = V - 1; v >= 0; v--) if (f[FPAY + v]) m_vc = v;
                end
            end else if (req_valid[m_gnt] && m_cred[m_vc] > 0) begin
                rdy[m_gnt] = 1'b1;
                f = req_flit[m_gnt*FW +: FW];
                f[FPAY +: V] = V'(1 << m_vc);
                exp_q.push_back(f);
                sent[m_vc] = 1;
                if (f[FW-2]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_gnt + 1) % N;
                end
            end
            check("req_ready", 64'(req_ready), 64'(rdy));
            m_acc = rdy;
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && sent[v] == 0 && m_cred[v] == B) m_err = 1'b1;
                else m_cred[v] = m_cred[v] - sent[v] + int'(credit_in[v]);
            end
        end
    end

    // Monitor and scoreboard.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 64'(flit_out_wr), 64'(0));
            end else begin
                check("wr_pulse", 64'(flit_out_wr), 64'(1));
                if (flit_out_wr) begin
                    check("flit_out", 64'(flit_out), 64'(exp_q[0]));
                    $display("tx flit %h hdr=%0b tail=%0b", flit_out, flit_out[FW-1], flit_out[FW-2]);
                end
                void'(exp_q.pop_front());
            end
            check("busy", 64'(busy), 64'(m_locked));
            check("credit_err", 64'(credit_err), 64'(m_err));
        end
    end

    // ---------------- driver helpers ----------------------------------------
    task automatic gen_pkt(input int r, input int len, input logic [V-1:0] vcf);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f               = '0;
            f[FW-1]         = (i == 0);
            f[FW-2]         = (i == len - 1);
            f[FPAY +: V]    = (i == 0) ? vcf : V'($urandom);
            f[FPAY-1:0]     = $urandom;
            src_q[r].push_back(f);
        end
    endtask

    // One clock: retire the flits the model accepted, then present new inputs.
    task automatic drive_step(input int vp, input int rp, input logic [V-1:0] force_cr);
        flit_t junk;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (m_acc[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
            junk = {$urandom, $urandom};
            if (src_q[r].size() > 0 && $urandom_range(99) < vp) begin
                req_valid[r]           = 1'b1;
                req_flit[r*FW +: FW]   = src_q[r][0];
            end else begin
                req_valid[r]           = 1'b0;
                req_flit[r*FW +: FW]   = junk;
            end
        end
        for (int v = 0; v < V; v++)
            credit_in[v] = force_cr[v] | ((m_cred[v] < B) && ($urandom_range(99) < rp));
    endtask

    function automatic bit quiet(input bit need_full);
        bit q;
        q = (exp_q.size() == 0) && !m_locked;
        for (int r = 0; r < N; r++) if (src_q[r].size() != 0) q = 1'b0;
        if (need_full) for (int v = 0; v < V; v++) if (m_cred[v] != B) q = 1'b0;
        return q;
    endfunction

    task automatic run_until_idle(input int max_cyc, input int vp, input int rp, input bit need_full);
        int c;
        c = 0;
        while (c < max_cyc && !quiet(need_full)) begin
            drive_step(vp, rp, '0);
            c++;
        end
        check("drain_timeout", 64'(c < max_cyc), 64'(1));
    endtask

    // ---------------- test sequence ------------------------------------------
    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_flit  = '0;
        credit_in = '0;
        @(posedge clk);
        #1;
        check("rst_flit_out", 64'(flit_out), 64'(0));
        check("rst_wr", 64'(flit_out_wr), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_credit_err", 64'(credit_err), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Requester 0 sends a 3-flit packet on VC0 with no credit returns.
        gen_pkt(0, 3, 2'b01);
        run_until_idle(20, 100, 0, 1'b0);
        run_until_idle(20, 100, 100, 1'b1);

        // All three requesters hold a 2-flit packet at once.
        for (int r = 0; r < N; r++) gen_pkt(r, 2, 2'b01);
        run_until_idle(60, 100, 100, 1'b1);

        // Requester 1 sends 6 flits on VC1. The stall after 4 flits is released
        // by two single credit pulses.
        gen_pkt(1, 6, 2'b10);
        repeat (10) drive_step(100, 0, '0);
        check("stall_ready", 64'(req_ready), 64'(0));
        drive_step(100, 0, 2'b10);
        repeat (3) drive_step(100, 0, '0);
        drive_step(100, 0, 2'b10);
        repeat (3) drive_step(100, 0, '0);
        run_until_idle(40, 100, 100, 1'b1);

        // Each send on VC0 is matched by a return in the same cycle.
        gen_pkt(0, 10, 2'b01);
        run_until_idle(40, 100, 100, 1'b1);

        // Random traffic: any VC field, valid gaps, random returns.
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(3) != 0) gen_pkt(r, $urandom_range(6, 1), V'($urandom));
            repeat (40) drive_step(70, 40, '0);
        end
        run_until_idle(600, 70, 60, 1'b1);

        // A credit returned to a full counter sets the sticky error flag.
        drive_step(0, 0, 2'b01);
        repeat (4) drive_step(0, 0, '0);
        check("credit_err_sticky", 64'(credit_err), 64'(1));
        gen_pkt(2, 3, 2'b10);
        run_until_idle(40, 100, 100, 1'b1);
        check("credit_err_held", 64'(credit_err), 64'(1));

        // Reset is asserted mid-packet, between clock edges.
        gen_pkt(1, 8, 2'b10);
        repeat (4) drive_step(100, 0, '0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_wr", 64'(flit_out_wr), 64'(0));
        check("arst_ready", 64'(req_ready), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_flit_out", 64'(flit_out), 64'(0));
        check("arst_credit_err", 64'(credit_err), 64'(0));
        for (int r = 0; r < N; r++) src_q[r].delete();
        req_valid = '0;
        credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // All 4 VC0 credits must be back, so 4 flits can go without returns.
        gen_pkt(2, 4, 2'b01);
        run_until_idle(30, 100, 0, 1'b0);
        run_until_idle(30, 100, 100, 1'b1);
        gen_pkt(0, 2, 2'b01);
        gen_pkt(1, 2, 2'b10);
        run_until_idle(30, 100, 100, 1'b1);

        repeat (2) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
